ddr3_rd_multi_burst: RTL and testbench
======================================

Name: ddr3_rd_multi_burst

Overview:
- Parametrised successor to the single-burst DDR3 read controller: reads a run of N consecutive bursts starting at a requested burst address.
- Pipelines several read commands to the memory user interface and buffers the returned data in an internal FIFO.
- Hands data to the requester over a valid/ready stream.
- Sits between the readout fill logic and the DDR3 address/command controller, in the DDR3 user-clock domain.

Parameters:
- DATA_W, 128: width of one memory burst and of the output stream.
- BADDR_W, 23: burst address width.
- ADDR_LSB, 3: zero bits appended below the burst address; rd_addr width = BADDR_W+ADDR_LSB.
- CNT_W, 8: width of the burst count.
- DEPTH, 4: output FIFO depth, which is also the maximum reads in flight (power of 2, ≥2).

Ports:
- clk  in  1  DDR3 user clock.
- reset_n  in  1  asynchronous, active-low reset.
- acq_enabled  in  1  acquisition (write) mode active; blocks the start of a read run.
- rd_req  in  1  level request from another domain; 2-flop synchronised internally.
- rd_start_addr  in  BADDR_W  first burst address; quasi-static while rd_req is high.
- rd_count  in  CNT_W  number of bursts; quasi-static while rd_req is high.
- rd_done  out  1  run complete; held until rd_req is synchronised low.
- rd_busy  out  1  high in every state except IDLE.
- rd_err  out  1  sticky: unexpected app_rd_data_valid received.
- dout  out  DATA_W  output burst data (FIFO head).
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts dout this cycle.
- app_rd_data_valid  in  1  memory read data valid.
- app_rd_data_end  in  1  last data cycle; unused, ignored.
- app_rd_data  in  DATA_W  memory read data.
- rd_app_rdy  in  1  address controller accepts the command this cycle.
- rd_app_en  out  1  read command request.
- rd_addr  out  BADDR_W+ADDR_LSB  command address = {cur_addr, ADDR_LSB zeros}.

Behaviour:
- Reset (async assert, sync deassert via clk): state IDLE; all outputs 0; counters, FIFO pointers and sync flops cleared; rd_addr 0.
- States and transitions:
  - IDLE -> ISSUE when rd_req_sync=1 and acq_enabled=0 and rd_count≠0. On entry, latch cur_addr=rd_start_addr, remaining=rd_count.
  - IDLE -> DONE when rd_req_sync=1, acq_enabled=0 and rd_count=0. No commands are issued.
  - ISSUE: rd_app_en=1 whenever credit is available. Credit = inflight + fifo_count < DEPTH.
    - A command is accepted when rd_app_en & rd_app_rdy. On accept: cur_addr+1 (wraps modulo 2^BADDR_W), remaining-1, inflight+1.
    - Without credit, rd_app_en=0 and rd_addr holds.
    - rd_app_en/rd_addr hold stable until accepted.
    - -> DRAIN on the cycle the last command is accepted (remaining=1).
  - DRAIN: no commands issued. -> DONE when inflight=0 and the FIFO is empty (all data consumed).
  - DONE: rd_done=1. -> IDLE when rd_req_sync=0; rd_done drops the same edge.
- acq_enabled is sampled only in IDLE; rising mid-run does not abort the run.
- rd_req falling mid-run does not abort; the run completes, then DONE exits immediately.
- Data return: each app_rd_data_valid with inflight>0 writes app_rd_data into the FIFO and decrements inflight.
  - Accept and return in the same cycle leaves inflight unchanged.
  - With inflight=0, data is dropped and rd_err is set (sticky until reset).
- Credit guarantees the FIFO never overflows.
- FIFO: first-word-fall-through; dout_valid = not empty; a pop occurs on dout_valid & dout_ready.
  - Simultaneous push and pop when full is impossible (credit); push and pop when empty/non-full are both honoured.
  - fifo_count uses CNT width log2(DEPTH)+1.
- Latency:
  - rd_req edge to first rd_app_en: 3 clk (2 sync flops + state register).
  - Memory data valid to dout_valid: 1 clk.
- Max throughput: one command/clk and one burst/clk, given ready consumer and memory.

Test Plan:
- Basic: rd_start_addr=0x000010, rd_count=4, rd_app_rdy=1, memory returns after 5 clk, dout_ready=1 -> rd_addr 0x80,0x88,0x90,0x98 on consecutive cycles; 4 beats out in order; rd_done high until rd_req low, then IDLE.
- Backpressure: DEPTH=4, rd_count=10, dout_ready=0 -> exactly 4 commands issued, rd_app_en then low; release dout_ready -> remaining 6 issued, all 10 beats output in order, no rd_err.
- Boundary: rd_count=0 -> rd_done with no rd_app_en. rd_start_addr=0x7FFFFF, rd_count=2 -> rd_addr 0x3FFFFF8 then 0x0000000.
- Blocking: acq_enabled=1 with rd_req=1 -> stays IDLE. Deassert acq_enabled -> run starts 1 clk later.
- Stall: rd_app_rdy low for 3 clk -> rd_app_en and rd_addr held stable until accept. Spurious app_rd_data_valid in IDLE -> rd_err=1, no dout_valid.
- Async reset: reset_n low mid-ISSUE with 2 beats in flight -> all outputs 0 immediately, without a clk edge. After release, a new run of 3 behaves normally.

Source files
------------

// File: rtl/ddr3_rd_multi_burst_if.sv
// Bus bundle for ddr3_rd_multi_burst: requester control, output stream,
// memory read-data return and the read command channel.
interface ddr3_rd_multi_burst_if #(
    parameter int DATA_W   = 128,
    parameter int BADDR_W  = 23,
    parameter int ADDR_LSB = 3,
    parameter int CNT_W    = 8
);
    // requester side
    logic                        acq_enabled;
    logic                        rd_req;
    logic [BADDR_W-1:0]          rd_start_addr;
    logic [CNT_W-1:0]            rd_count;
    logic                        rd_done;
    logic                        rd_busy;
    logic                        rd_err;
    // output stream
    logic [DATA_W-1:0]           dout;
    logic                        dout_valid;
    logic                        dout_ready;
    // memory read data return
    logic                        app_rd_data_valid;
    logic                        app_rd_data_end;
    logic [DATA_W-1:0]           app_rd_data;
    // read command channel
    logic                        rd_app_rdy;
    logic                        rd_app_en;
    logic [BADDR_W+ADDR_LSB-1:0] rd_addr;

    // read controller view
    modport slave (
        input  acq_enabled, rd_req, rd_start_addr, rd_count,
        input  dout_ready,
        input  app_rd_data_valid, app_rd_data_end, app_rd_data,
        input  rd_app_rdy,
        output rd_done, rd_busy, rd_err,
        output dout, dout_valid,
        output rd_app_en, rd_addr
    );

    // environment view (requester, consumer, memory and command controller)
    modport master (
        output acq_enabled, rd_req, rd_start_addr, rd_count,
        output dout_ready,
        output app_rd_data_valid, app_rd_data_end, app_rd_data,
        output rd_app_rdy,
        input  rd_done, rd_busy, rd_err,
        input  dout, dout_valid,
        input  rd_app_en, rd_addr
    );
endinterface

// File: rtl/ddr3_rd_multi_burst.sv
// ddr3_rd_multi_burst: reads a run of consecutive DDR3 bursts starting at a
// requested burst address. Read commands are pipelined up to DEPTH deep and
// the returned bursts are buffered in a first-word-fall-through FIFO that
// feeds a valid/ready output stream. Commands are only issued while there is
// room for their data (inflight + fifo_count < DEPTH), so the FIFO can never
// overflow even with a stalled consumer.
module ddr3_rd_multi_burst #(
    parameter int DATA_W   = 128,
    parameter int BADDR_W  = 23,
    parameter int ADDR_LSB = 3,
    parameter int CNT_W    = 8,
    parameter int DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ddr3_rd_multi_burst_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FC_W-1:0]    FC_ZERO      = {FC_W{1'b0}};
    localparam logic [FC_W-1:0]    FC_ONE       = {{(FC_W-1){1'b0}}, 1'b1};
    localparam logic [FC_W:0]      CREDIT_LIMIT = (FC_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ZERO     = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]   PTR_ONE      = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [BADDR_W-1:0] BADDR_ZERO   = {BADDR_W{1'b0}};
    localparam logic [BADDR_W-1:0] BADDR_ONE    = {{(BADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]  DATA_ZERO    = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic               rd_req_meta_r;
    logic               rd_req_sync_r;

    logic [BADDR_W-1:0] cur_addr_r;
    logic [CNT_W-1:0]   remaining_r;
    logic [FC_W-1:0]    inflight_r;
    logic [FC_W-1:0]    inflight_nxt_s;
    logic               rd_err_r;

    logic [DATA_W-1:0]  fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [FC_W-1:0]    fifo_count_r;
    logic [FC_W-1:0]    fifo_count_nxt_s;

    logic               start_s;
    logic               credit_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               stray_s;
    logic               fifo_empty_s;

    // The end-of-data marker carries no information for single-beat bursts.
    logic               unused_data_end_s;
    assign unused_data_end_s = bus.app_rd_data_end;

    // Credit counts both outstanding reads and buffered bursts, so every
    // accepted command is guaranteed a FIFO slot when its data returns.
    assign credit_s     = ({1'b0, inflight_r} + {1'b0, fifo_count_r}) < CREDIT_LIMIT;
    assign accept_s     = bus.rd_app_en & bus.rd_app_rdy;
    assign push_s       = bus.app_rd_data_valid & (inflight_r != FC_ZERO);
    assign stray_s      = bus.app_rd_data_valid & (inflight_r == FC_ZERO);
    assign fifo_empty_s = (fifo_count_r == FC_ZERO);
    assign pop_s        = bus.dout_valid & bus.dout_ready;

    // Outputs are pure decodes of registered state.
    assign bus.rd_app_en  = (state_r == ST_ISSUE) & credit_s;
    assign bus.rd_addr    = {cur_addr_r, {ADDR_LSB{1'b0}}};
    assign bus.rd_busy    = (state_r != ST_IDLE);
    assign bus.rd_done    = (state_r == ST_DONE);
    assign bus.rd_err     = rd_err_r;
    assign bus.dout_valid = ~fifo_empty_s;
    assign bus.dout       = fifo_mem_r[rd_ptr_r];

    // Two-flop synchroniser for the request level arriving from another domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req_meta_r <= 1'b0;
            rd_req_sync_r <= 1'b0;
        end else begin
            rd_req_meta_r <= bus.rd_req;
            rd_req_sync_r <= rd_req_meta_r;
        end
    end

    // Run-control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; acq_enabled only gates the start of a run.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rd_req_sync_r && !bus.acq_enabled) begin
                    if (bus.rd_count != CNT_ZERO) begin
                        state_nxt_s = ST_ISSUE;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s && (remaining_r == CNT_ONE)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if ((inflight_r == FC_ZERO) && fifo_empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!rd_req_sync_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Command address and remaining-burst counter; address wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr_r  <= BADDR_ZERO;
            remaining_r <= CNT_ZERO;
        end else if (start_s) begin
            cur_addr_r  <= bus.rd_start_addr;
            remaining_r <= bus.rd_count;
        end else if (accept_s) begin
            cur_addr_r  <= cur_addr_r + BADDR_ONE;
            remaining_r <= remaining_r - CNT_ONE;
        end
    end

    // Outstanding reads: +1 per accepted command, -1 per returned burst.
    always_comb begin
        inflight_nxt_s = inflight_r;
        if (accept_s && !push_s) begin
            inflight_nxt_s = inflight_r + FC_ONE;
        end else if (!accept_s && push_s) begin
            inflight_nxt_s = inflight_r - FC_ONE;
        end else begin
            inflight_nxt_s = inflight_r;
        end
    end

    // Outstanding-read counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= FC_ZERO;
        end else begin
            inflight_r <= inflight_nxt_s;
        end
    end

    // Sticky flag for read data that no command asked for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_err_r <= 1'b0;
        end else if (stray_s) begin
            rd_err_r <= 1'b1;
        end
    end

    // FIFO occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        fifo_count_nxt_s = fifo_count_r;
        if (push_s && !pop_s) begin
            fifo_count_nxt_s = fifo_count_r + FC_ONE;
        end else if (!push_s && pop_s) begin
            fifo_count_nxt_s = fifo_count_r - FC_ONE;
        end else begin
            fifo_count_nxt_s = fifo_count_r;
        end
    end

    // FIFO pointers and occupancy; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            fifo_count_r <= FC_ZERO;
        end else begin
            fifo_count_r <= fifo_count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; cleared on reset so dout reads zero while empty after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= DATA_ZERO;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.app_rd_data;
        end
    end

endmodule

// File: tb/tb_ddr3_rd_multi_burst.sv
// Testbench for ddr3_rd_multi_burst: a table of read runs with hand-computed
// command addresses, plus directed sequences for blocking, command stalls,
// early request release, stray read data and asynchronous reset.
module tb_ddr3_rd_multi_burst;

    localparam int DATA_W   = 128;
    localparam int BADDR_W  = 23;
    localparam int ADDR_LSB = 3;
    localparam int CNT_W    = 8;
    localparam int DEPTH    = 4;
    localparam int LAT      = 5;

    typedef struct {
        logic [22:0] start;
        logic [7:0]  count;
        int          hold;       // cycles with dout_ready low at run start
        int          exp_held;   // commands issued by the end of the hold
        logic [25:0] exp_first;
        logic [25:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic spur_req = 1'b0;
    logic dv_prev = 1'b0;

    logic [25:0]  cmd_q[$];
    int           cmd_cyc_q[$];
    logic [25:0]  ret_q[$];
    int           due_q[$];
    int           rv_cyc_q[$];
    int           dv_rise_q[$];
    logic [127:0] beat_q[$];

    ddr3_rd_multi_burst_if #(.DATA_W(DATA_W), .BADDR_W(BADDR_W), .ADDR_LSB(ADDR_LSB), .CNT_W(CNT_W)) bus ();

    ddr3_rd_multi_burst #(
        .DATA_W(DATA_W), .BADDR_W(BADDR_W), .ADDR_LSB(ADDR_LSB), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] data_for(input logic [25:0] a);
        data_for = {4{32'hC0DE_0000 ^ {6'd0, a}}};
    endfunction

    // Monitor and memory model: sample at the falling edge, record accepted
    // commands and output beats, and present read data LAT cycles later.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            ret_q.delete();
            due_q.delete();
            dv_prev = 1'b0;
            bus.app_rd_data_valid = 1'b0;
            bus.app_rd_data = 128'd0;
        end else begin
            if (bus.rd_app_en && bus.rd_app_rdy) begin
                cmd_q.push_back(bus.rd_addr);
                cmd_cyc_q.push_back(cyc);
                ret_q.push_back(bus.rd_addr);
                due_q.push_back(cyc + LAT);
            end
            if (bus.dout_valid && !dv_prev) dv_rise_q.push_back(cyc);
            dv_prev = bus.dout_valid;
            if (bus.dout_valid && bus.dout_ready) beat_q.push_back(bus.dout);
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                bus.app_rd_data_valid = 1'b1;
                bus.app_rd_data = data_for(ret_q.pop_front());
                void'(due_q.pop_front());
                rv_cyc_q.push_back(cyc);
            end else if (spur_req) begin
                bus.app_rd_data_valid = 1'b1;
                bus.app_rd_data = 128'hDEAD_BEEF;
                rv_cyc_q.push_back(cyc);
            end else begin
                bus.app_rd_data_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pwait();
        @(posedge clk);
        #1;
    endtask

    task automatic nwait();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (bus.rd_done !== 1'b1 && n < budget) begin
            nwait();
            n++;
        end
        check(name, bus.rd_done, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.rd_busy !== 1'b0 && n < 100) begin
            nwait();
            n++;
        end
        check(name, bus.rd_busy, 1'b0);
        check({name, "_done"}, bus.rd_done, 1'b0);
    endtask

    task automatic do_run(input vec_t v);
        int cb, bb, rb, db, req_cyc, en_cyc, rv_cyc, dv_cyc;
        logic ok;
        logic [22:0] a;
        logic [25:0] ea;
        cb = cmd_q.size(); bb = beat_q.size(); rb = rv_cyc_q.size(); db = dv_rise_q.size();
        pwait();
        bus.rd_start_addr = v.start;
        bus.rd_count = v.count;
        bus.rd_app_rdy = 1'b1;
        bus.dout_ready = (v.hold == 0);
        bus.rd_req = 1'b1;
        req_cyc = cyc + 1;
        if (v.hold > 0) begin
            repeat (v.hold) nwait();
            check("held_cmds", cmd_q.size() - cb, v.exp_held);
            check("held_en_low", bus.rd_app_en, 1'b0);
            check("held_dout_valid", bus.dout_valid, 1'b1);
            pwait();
            bus.dout_ready = 1'b1;
        end
        wait_done("run_done", 400);
        check("n_cmds", cmd_q.size() - cb, int'(v.count));
        check("n_beats", beat_q.size() - bb, int'(v.count));
        if (v.count != 8'd0) begin
            check("first_addr", (cmd_q.size() > cb) ? cmd_q[cb] : 26'h3FFFFFF, v.exp_first);
            check("last_addr", (cmd_q.size() > cb) ? cmd_q[$] : 26'h3FFFFFF, v.exp_last);
            en_cyc = (cmd_cyc_q.size() > cb) ? cmd_cyc_q[cb] : -1000;
            check("req_to_en_latency", en_cyc - req_cyc, 3);
            rv_cyc = (rv_cyc_q.size() > rb) ? rv_cyc_q[rb] : -1000;
            dv_cyc = (dv_rise_q.size() > db) ? dv_rise_q[db] : 1000;
            check("data_to_dout_latency", dv_cyc - rv_cyc, 1);
            ok = 1'b1;
            for (int i = 0; i < int'(v.count); i++) begin
                a = v.start + 23'(i);
                ea = {a, 3'b000};
                if (cb + i >= cmd_q.size() || cmd_q[cb + i] !== ea) ok = 1'b0;
                if (bb + i >= beat_q.size() || beat_q[bb + i] !== data_for(ea)) ok = 1'b0;
            end
            check("addr_data_order", ok, 1'b1);
        end
        check("no_err", bus.rd_err, 1'b0);
        nwait();
        nwait();
        check("done_held", bus.rd_done, 1'b1);
        pwait();
        bus.rd_req = 1'b0;
        wait_idle("back_to_idle");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cb, n, t;
        vecs[0] = '{23'h000010, 8'd4,  0,  0, 26'h0000080, 26'h0000098};
        vecs[1] = '{23'h7FFFFF, 8'd2,  0,  0, 26'h3FFFFF8, 26'h0000000};
        vecs[2] = '{23'h000200, 8'd10, 40, 4, 26'h0001000, 26'h0001048};
        vecs[3] = '{23'h000000, 8'd0,  0,  0, 26'h0000000, 26'h0000000};
        vecs[4] = '{23'h123456, 8'd10, 0,  0, 26'h091A2B0, 26'h091A2F8};
        vecs[5] = '{23'h7FFFFE, 8'd3,  0,  0, 26'h3FFFFF0, 26'h0000000};

        reset_n = 1'b0;
        bus.acq_enabled = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_start_addr = 23'd0;
        bus.rd_count = 8'd0;
        bus.dout_ready = 1'b0;
        bus.rd_app_rdy = 1'b0;
        bus.app_rd_data_end = 1'b0;
        repeat (3) pwait();
        reset_n = 1'b1;
        nwait();
        check("rst_busy", bus.rd_busy, 1'b0);
        check("rst_done", bus.rd_done, 1'b0);
        check("rst_err", bus.rd_err, 1'b0);
        check("rst_dout_valid", bus.dout_valid, 1'b0);
        check("rst_app_en", bus.rd_app_en, 1'b0);
        check("rst_addr", bus.rd_addr, 26'h0);

        for (int i = 0; i < 6; i++) do_run(vecs[i]);

        // acq_enabled blocks the start; releasing it starts the run one clock later
        cb = cmd_q.size();
        pwait();
        bus.acq_enabled = 1'b1;
        bus.rd_start_addr = 23'h000040;
        bus.rd_count = 8'd2;
        bus.rd_app_rdy = 1'b1;
        bus.dout_ready = 1'b1;
        bus.rd_req = 1'b1;
        repeat (10) nwait();
        check("blk_idle", bus.rd_busy, 1'b0);
        check("blk_no_cmd", cmd_q.size() - cb, 0);
        pwait();
        bus.acq_enabled = 1'b0;
        t = cyc + 1;
        n = 0;
        while (cmd_q.size() == cb && n < 20) begin nwait(); n++; end
        check("blk_start_latency", ((cmd_cyc_q.size() > cb) ? cmd_cyc_q[cb] : -1000) - t, 1);
        pwait();
        bus.acq_enabled = 1'b1;
        wait_done("blk_done", 100);
        check("blk_cmds", cmd_q.size() - cb, 2);
        pwait();
        bus.rd_req = 1'b0;
        bus.acq_enabled = 1'b0;
        wait_idle("blk_idle_after");

        // command channel stalled: rd_app_en and rd_addr hold until accepted
        cb = cmd_q.size();
        pwait();
        bus.rd_app_rdy = 1'b0;
        bus.rd_start_addr = 23'h000020;
        bus.rd_count = 8'd2;
        bus.rd_req = 1'b1;
        n = 0;
        while (bus.rd_app_en !== 1'b1 && n < 20) begin nwait(); n++; end
        for (int i = 0; i < 3; i++) begin
            check("stall_en", bus.rd_app_en, 1'b1);
            check("stall_addr", bus.rd_addr, 26'h0000100);
            nwait();
        end
        pwait();
        bus.rd_app_rdy = 1'b1;
        wait_done("stall_done", 100);
        check("stall_cmds", cmd_q.size() - cb, 2);
        check("stall_addr0", (cmd_q.size() > cb) ? cmd_q[cb] : 26'h3FFFFFF, 26'h0000100);
        check("stall_addr1", (cmd_q.size() > cb + 1) ? cmd_q[cb + 1] : 26'h3FFFFFF, 26'h0000108);
        pwait();
        bus.rd_req = 1'b0;
        wait_idle("stall_idle");

        // request dropped mid-run: run completes, then returns straight to IDLE
        cb = cmd_q.size();
        n = beat_q.size();
        pwait();
        bus.rd_start_addr = 23'h000030;
        bus.rd_count = 8'd3;
        bus.rd_req = 1'b1;
        t = 0;
        while (cmd_q.size() == cb && t < 20) begin nwait(); t++; end
        pwait();
        bus.rd_req = 1'b0;
        wait_idle("early_release_idle");
        check("early_release_cmds", cmd_q.size() - cb, 3);
        check("early_release_beats", beat_q.size() - n, 3);

        // stray read data in IDLE sets the sticky error and is dropped
        pwait();
        spur_req = 1'b1;
        pwait();
        spur_req = 1'b0;
        nwait();
        nwait();
        check("stray_err", bus.rd_err, 1'b1);
        check("stray_no_dout", bus.dout_valid, 1'b0);
        check("stray_idle", bus.rd_busy, 1'b0);

        // asynchronous reset in the middle of ISSUE with reads in flight
        cb = cmd_q.size();
        pwait();
        bus.rd_start_addr = 23'h000050;
        bus.rd_count = 8'd8;
        bus.rd_req = 1'b1;
        n = 0;
        while (cmd_q.size() < cb + 3 && n < 30) begin nwait(); n++; end
        check("arst_pre_busy", bus.rd_busy, 1'b1);
        check("arst_pre_en", bus.rd_app_en, 1'b1);
        #1;
        reset_n = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        check("arst_app_en", bus.rd_app_en, 1'b0);
        check("arst_addr", bus.rd_addr, 26'h0);
        check("arst_busy", bus.rd_busy, 1'b0);
        check("arst_done", bus.rd_done, 1'b0);
        check("arst_err", bus.rd_err, 1'b0);
        check("arst_dout_valid", bus.dout_valid, 1'b0);
        check("arst_dout", bus.dout, 128'd0);
        repeat (3) pwait();
        reset_n = 1'b1;
        repeat (2) nwait();
        do_run('{23'h000400, 8'd3, 0, 0, 26'h0002000, 26'h0002010});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
